// File: rtl/modred_pkg.sv
// rtl/modred_pkg.sv - shared types and constants for the modular reducer
// Purpose: state encoding and default width shared by modular_reducer,
//          its interface and the cond_sub datapath.
// Ports:   none (package).
package modred_pkg;

  localparam int WIDTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Plain-vector copies of the state codes for the FSM register.
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_REDUCE = REDUCE;
  localparam logic [1:0] S_DONE   = DONE;

endpackage

// File: rtl/modular_reducer_if.sv
// rtl/modular_reducer_if.sv - operand/result bundle of the modular reducer
// Purpose: groups the request operands and the result/status signals.
// Ports:   product_in, modulus_in, valid_in   (master -> slave)
//          result_out, valid_out, busy_out, err_out, quot_out (slave -> master)
//          quot_out exists only when MODRED_QUOTIENT_EN is defined.
interface modular_reducer_if #(
  parameter int WIDTH = modred_pkg::WIDTH_DEFAULT
);

  logic [2*WIDTH-1:0] product_in;
  logic [WIDTH-1:0]   modulus_in;
  logic               valid_in;
  logic [WIDTH-1:0]   result_out;
  logic               valid_out;
  logic               busy_out;
  logic               err_out;

`ifdef MODRED_QUOTIENT_EN
  logic [2*WIDTH-1:0] quot_out;

  modport master (
    output product_in, modulus_in, valid_in,
    input  result_out, valid_out, busy_out, err_out, quot_out
  );

  modport slave (
    input  product_in, modulus_in, valid_in,
    output result_out, valid_out, busy_out, err_out, quot_out
  );
`else
  modport master (
    output product_in, modulus_in, valid_in,
    input  result_out, valid_out, busy_out, err_out
  );

  modport slave (
    input  product_in, modulus_in, valid_in,
    output result_out, valid_out, busy_out, err_out
  );
`endif

endinterface

// File: rtl/modular_reducer_cond_sub.sv
// rtl/modular_reducer_cond_sub.sv - one restoring-division compare/subtract step
// Purpose: combinational (W+1)-bit compare of t against n, subtracting n
//          when t >= n.
// Ports:   t      in  W+1  partial remainder with next dividend bit appended
//          n      in  W    modulus
//          r_next out W    t-n if ge else t (always fits in W bits)
//          ge     out 1    t >= n
module cond_sub #(
  parameter int WIDTH = modred_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r_next,
  output logic             ge
);

  logic [WIDTH:0] n_ext;

  assign n_ext = {1'b0, n};
  assign ge    = (t >= n_ext);
  // r < n before the step, so t < 2n and t - n < n fits in W bits.
  assign r_next = ge ? WIDTH'(t - n_ext) : t[WIDTH-1:0];

endmodule

// File: rtl/modular_reducer.sv
// rtl/modular_reducer.sv - bit-serial restoring reducer r = p mod n
// Purpose: reduces a 2W-bit product modulo a W-bit modulus, one dividend bit
//          per cycle, MSB first. Operands are latched on accept.
//          Optional macro MODRED_QUOTIENT_EN adds the quotient register and
//          quot_out.
// Ports:   clk_in  in  system clock
//          rst_in  in  synchronous active-high reset
//          bus     modular_reducer_if.slave (operands, result, status)
module modular_reducer
  import modred_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  modular_reducer_if.slave   bus
);

  localparam int              IW       = $clog2(2*WIDTH);
  localparam logic [IW-1:0]   IDX_LAST = IW'(2*WIDTH-1);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   n_reg;
  logic [WIDTH-1:0]   r_reg;
  logic [IW-1:0]      idx;

  logic [WIDTH:0]     t;
  logic [WIDTH-1:0]   r_next;
  logic               ge;

  // p_reg shifts left each step, so its MSB is always dividend bit idx.
  assign t = {r_reg, p_reg[2*WIDTH-1]};

  cond_sub #(.WIDTH(WIDTH)) u_cond_sub (
    .t      (t),
    .n      (n_reg),
    .r_next (r_next),
    .ge     (ge)
  );

`ifdef MODRED_QUOTIENT_EN
  logic [2*WIDTH-1:0] q_reg;
  logic [2*WIDTH-1:0] q_next;

  assign q_next = (q_reg << 1) | {{(2*WIDTH-1){1'b0}}, ge};
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      p_reg          <= '0;
      n_reg          <= '0;
      r_reg          <= '0;
      idx            <= '0;
      bus.result_out <= '0;
      bus.valid_out  <= 1'b0;
      bus.busy_out   <= 1'b0;
      bus.err_out    <= 1'b0;
`ifdef MODRED_QUOTIENT_EN
      q_reg          <= '0;
      bus.quot_out   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.valid_in) begin
            bus.busy_out <= 1'b1;
            if (bus.modulus_in != '0) begin
              p_reg       <= bus.product_in;
              n_reg       <= bus.modulus_in;
              r_reg       <= '0;
              idx         <= IDX_LAST;
              bus.err_out <= 1'b0;
`ifdef MODRED_QUOTIENT_EN
              q_reg       <= '0;
`endif
              state       <= S_REDUCE;
            end else begin
              // Zero modulus: report an error immediately, no reduction.
              bus.result_out <= '0;
              bus.err_out    <= 1'b1;
              bus.valid_out  <= 1'b1;
`ifdef MODRED_QUOTIENT_EN
              bus.quot_out   <= '0;
`endif
              state          <= S_DONE;
            end
          end
        end
        S_REDUCE: begin
          r_reg <= r_next;
          p_reg <= p_reg << 1;
`ifdef MODRED_QUOTIENT_EN
          q_reg <= q_next;
`endif
          if (idx == '0) begin
            bus.result_out <= r_next;
            bus.valid_out  <= 1'b1;
`ifdef MODRED_QUOTIENT_EN
            bus.quot_out   <= q_next;
`endif
            state          <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE: begin
          bus.valid_out <= 1'b0;
          bus.busy_out  <= 1'b0;
          state         <= S_IDLE;
        end
        default: begin
          bus.valid_out <= 1'b0;
          bus.busy_out  <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modular_reducer.sv
// tb/tb_modular_reducer.sv - scoreboard bench for modular_reducer at W=8 and W=256
module tb_modular_reducer;

  typedef struct {
    logic [511:0] r;
    logic         err;
    logic [511:0] q;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passc = 0;
  exp_t q8[$];
  exp_t q256[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  modular_reducer_if #(.WIDTH(8))   b8 ();
  modular_reducer_if #(.WIDTH(256)) b256 ();

  modular_reducer #(.WIDTH(8))   dut8   (.clk_in(clk), .rst_in(rst), .bus(b8));
  modular_reducer #(.WIDTH(256)) dut256 (.clk_in(clk), .rst_in(rst), .bus(b256));

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passc++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Monitors: pop one expectation per valid_out pulse.
  always @(negedge clk) begin
    if (!rst && b8.valid_out === 1'b1) begin
      if (q8.size() == 0) chk("w8_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_result", 512'(b8.result_out), e.r);
        chk("w8_err", 512'(b8.err_out), 512'(e.err));
        chk("w8_latency", 512'(cyc - e.acc), 512'(e.lat));
`ifdef MODRED_QUOTIENT_EN
        chk("w8_quot", 512'(b8.quot_out), e.q);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b256.valid_out === 1'b1) begin
      if (q256.size() == 0) chk("w256_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q256.pop_front();
        chk("w256_result", 512'(b256.result_out), e.r);
        chk("w256_err", 512'(b256.err_out), 512'(e.err));
        chk("w256_latency", 512'(cyc - e.acc), 512'(e.lat));
`ifdef MODRED_QUOTIENT_EN
        chk("w256_quot", b256.quot_out, e.q);
`endif
      end
    end
  end

  task automatic drain8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      chk("w8_timeout", 512'(q8.size()), 0);
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain256();
    for (int i = 0; i < 700 && q256.size() != 0; i++) @(negedge clk);
    if (q256.size() != 0) begin
      chk("w256_timeout", 512'(q256.size()), 0);
      q256.delete();
    end
    @(negedge clk);
  endtask

  // Drive one request (valid_in for one cycle) and push its expectation.
  task automatic start8(input logic [15:0] p, input logic [7:0] n,
                        input logic [7:0] r, input logic err, input logic [15:0] q);
    exp_t e;
    @(negedge clk);
    b8.product_in = p;
    b8.modulus_in = n;
    b8.valid_in   = 1'b1;
    e.r = 512'(r); e.err = err; e.q = 512'(q);
    e.lat = err ? 0 : 16;
    e.acc = cyc + 1;
    q8.push_back(e);
    @(negedge clk);
    b8.valid_in = 1'b0;
  endtask

  task automatic job8(input logic [15:0] p, input logic [7:0] n,
                      input logic [7:0] r, input logic [15:0] q);
    start8(p, n, r, 1'b0, q);
    drain8();
  endtask

  task automatic job256(input logic [511:0] p, input logic [511:0] n);
    exp_t e;
    @(negedge clk);
    b256.product_in = p;
    b256.modulus_in = n[255:0];
    b256.valid_in   = 1'b1;
    e.r = p % n; e.err = 1'b0; e.q = p / n;
    e.lat = 512;
    e.acc = cyc + 1;
    q256.push_back(e);
    @(negedge clk);
    b256.valid_in = 1'b0;
    drain256();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] p;
    logic [511:0] n;
    b8.product_in = '0; b8.modulus_in = '0; b8.valid_in = 1'b0;
    b256.product_in = '0; b256.modulus_in = '0; b256.valid_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid8", 512'(b8.valid_out), 0);
    chk("rst_busy8", 512'(b8.busy_out), 0);
    chk("rst_result8", 512'(b8.result_out), 0);
    chk("rst_err8", 512'(b8.err_out), 0);
    chk("rst_busy256", 512'(b256.busy_out), 0);
    chk("rst_result256", 512'(b256.result_out), 0);
    rst = 1'b0;

    // 1..3: directed W=8 vectors
    job8(16'h1234, 8'd97, 8'd4, 16'h0030);
    job8(16'hFFFF, 8'd255, 8'd0, 16'h0101);
    job8(16'hFFFF, 8'd251, 8'd24, 16'h0105);
    job8(16'h0005, 8'd7, 8'd5, 16'h0000);
    job8(16'h0000, 8'd13, 8'd0, 16'h0000);
    job8(16'h00FF, 8'd1, 8'd0, 16'h00FF);

    // 4: zero modulus
    start8(16'h1234, 8'd0, 8'd0, 1'b1, 16'h0000);
    chk("zero_n_busy_after_accept", 512'(b8.busy_out), 1);
    @(negedge clk);
    chk("zero_n_busy_two_edges", 512'(b8.busy_out), 0);
    drain8();

    // 5: valid_in during REDUCE is ignored
    start8(16'h1234, 8'd97, 8'd4, 1'b0, 16'h0030);
    repeat (4) @(negedge clk);
    b8.product_in = 16'hFFFF;
    b8.modulus_in = 8'd251;
    b8.valid_in   = 1'b1;
    @(negedge clk);
    b8.valid_in = 1'b0;
    chk("busy_during_reduce", 512'(b8.busy_out), 1);
    drain8();
    repeat (30) @(negedge clk);

    // 6: reset mid-REDUCE aborts the job without a valid_out
    start8(16'hFFFF, 8'd255, 8'd0, 1'b0, 16'h0101);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    chk("midrst_result", 512'(b8.result_out), 0);
    chk("midrst_valid", 512'(b8.valid_out), 0);
    chk("midrst_busy", 512'(b8.busy_out), 0);
    chk("midrst_err", 512'(b8.err_out), 0);
`ifdef MODRED_QUOTIENT_EN
    chk("midrst_quot", 512'(b8.quot_out), 0);
`endif
    rst = 1'b0;
    repeat (40) @(negedge clk);
    job8(16'h1234, 8'd97, 8'd4, 16'h0030);

    // W=256: max dividend with n = 2^256-1, a small dividend, and random operands
    job256({512{1'b1}}, {256'h0, {256{1'b1}}});
    n = '0;
    for (int i = 0; i < 8; i++) n[32*i +: 32] = $urandom;
    n[255] = 1'b1;
    job256(512'd12345, n);
    for (int k = 0; k < 2; k++) begin
      p = '0;
      n = '0;
      for (int i = 0; i < 16; i++) p[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) n[32*i +: 32] = $urandom;
      n[0] = 1'b1;
      job256(p, n);
    end

    chk("w8_queue_empty", 512'(q8.size()), 0);
    chk("w256_queue_empty", 512'(q256.size()), 0);
    $display("%0d/%0d checks passed", passc, total);
    $finish;
  end

endmodule
